// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, arbiter states and sizing helpers.
package sdram_pkg;

  // Commands as {cs_n, ras_n, cas_n, we_n}.
  localparam logic [3:0] CmdNop  = 4'b0111;
  localparam logic [3:0] CmdPre  = 4'b0010;
  localparam logic [3:0] CmdAref = 4'b0001;
  localparam logic [3:0] CmdMrs  = 4'b0000;
  localparam logic [3:0] CmdAct  = 4'b0011;
  localparam logic [3:0] CmdWr   = 4'b0100;
  localparam logic [3:0] CmdRd   = 4'b0101;

  typedef enum logic [3:0] {
    StInit  = 4'b0001,
    StArbit = 4'b0010,
    StRef   = 4'b0100,
    StGrant = 4'b1000
  } state_e;

  function automatic int unsigned idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping around.
module rr_pick
  import sdram_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  localparam int unsigned IdxW  = idx_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IdxW-1:0]   ptr,
  output logic              valid,
  output logic [IdxW-1:0]   idx
);

  logic [IdxW:0] cand;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      cand = {1'b0, ptr} + (IdxW + 1)'(k);
      if (cand >= (IdxW + 1)'(NUM_CH)) begin
        cand = cand - (IdxW + 1)'(NUM_CH);
      end
      if (!valid && req[cand[IdxW-1:0]]) begin
        valid = 1'b1;
        idx   = cand[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/sdram_mc_arbiter.sv
// Multi-channel SDRAM command arbiter: refresh first, clients round-robin, per-tenure
// watchdog, and the pad multiplexer for the current pin owner.
module sdram_mc_arbiter
  import sdram_pkg::*;
#(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned BANK_W    = 2,
  parameter int unsigned DQ_W      = 16,
  parameter int unsigned MAX_GRANT = 1023,
  localparam int unsigned DQM_W    = DQ_W / 8,
  localparam int unsigned IdW      = idx_w(NUM_CH)
) (
  input  logic                       sclk,
  input  logic                       s_rst_n,
  input  logic                       init_end,
  input  logic [3:0]                 init_cmd,
  input  logic [ADDR_W-1:0]          init_addr,
  input  logic                       ref_req,
  output logic                       ref_en,
  input  logic                       ref_end,
  input  logic [3:0]                 ref_cmd,
  input  logic [ADDR_W-1:0]          ref_addr,
  input  logic [NUM_CH-1:0]          ch_req,
  output logic [NUM_CH-1:0]          ch_en,
  input  logic [NUM_CH-1:0]          ch_end,
  input  logic [4*NUM_CH-1:0]        ch_cmd,
  input  logic [ADDR_W*NUM_CH-1:0]   ch_addr,
  input  logic [BANK_W*NUM_CH-1:0]   ch_bank,
  input  logic [DQ_W*NUM_CH-1:0]     ch_dq_o,
  input  logic [NUM_CH-1:0]          ch_dq_oe,
  input  logic [DQM_W*NUM_CH-1:0]    ch_dqm,
  output logic [DQ_W-1:0]            dq_i,
  output logic [IdW-1:0]             grant_id,
  output logic                       busy,
  output logic                       timeout_err,
  output logic                       sdram_clk,
  output logic                       sdram_cke,
  output logic                       sdram_cs_n,
  output logic                       sdram_ras_n,
  output logic                       sdram_cas_n,
  output logic                       sdram_we_n,
  output logic [BANK_W-1:0]          sdram_bank,
  output logic [ADDR_W-1:0]          sdram_addr,
  output logic [DQM_W-1:0]           sdram_dqm,
  inout  wire  [DQ_W-1:0]            sdram_dq
);

  localparam int unsigned CntW = $clog2(MAX_GRANT);

  state_e              state_q, state_d;
  logic [IdW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]      grant_id_q, grant_id_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                ref_en_q, ref_en_d;
  logic [NUM_CH-1:0]   ch_en_q, ch_en_d;

  logic                pick_valid;
  logic [IdW-1:0]      pick_idx;
  logic [IdW-1:0]      ptr_next;
  logic                end_flag;
  logic                wd_expire;
  logic [3:0]          cmd;
  logic                dq_oe;
  logic [DQ_W-1:0]     dq_out;

  rr_pick #(
    .NUM_CH (NUM_CH)
  ) u_rr_pick (
    .req   (ch_req),
    .ptr   (rr_ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign ptr_next  = (grant_id_q == IdW'(NUM_CH - 1)) ? '0 : grant_id_q + 1'b1;
  assign end_flag  = (state_q == StRef) ? ref_end : ch_end[grant_id_q];
  assign wd_expire = (cnt_q == CntW'(MAX_GRANT - 1));

  always_ff @(posedge sclk) begin
    if (!s_rst_n) begin
      state_q    <= StInit;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      cnt_q      <= '0;
      ref_en_q   <= 1'b0;
      ch_en_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      cnt_q      <= cnt_d;
      ref_en_q   <= ref_en_d;
      ch_en_q    <= ch_en_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    cnt_d      = '0;
    ref_en_d   = 1'b0;
    ch_en_d    = '0;
    unique case (state_q)
      StInit: begin
        if (init_end) state_d = StArbit;
      end
      StArbit: begin
        // Refresh outranks every client; a waiting client keeps its rr position.
        if (ref_req) begin
          state_d  = StRef;
          ref_en_d = 1'b1;
        end else if (pick_valid) begin
          state_d    = StGrant;
          grant_id_d = pick_idx;
          ch_en_d    = NUM_CH'(1) << pick_idx;
        end
      end
      StRef: begin
        cnt_d = cnt_q + 1'b1;
        if (ref_end || wd_expire) state_d = StArbit;
      end
      StGrant: begin
        cnt_d = cnt_q + 1'b1;
        if (ch_end[grant_id_q] || wd_expire) begin
          state_d  = StArbit;
          rr_ptr_d = ptr_next;
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_comb begin
    cmd        = CmdNop;
    sdram_addr = '0;
    sdram_bank = '0;
    sdram_dqm  = '0;
    dq_oe      = 1'b0;
    dq_out     = ch_dq_o[grant_id_q*DQ_W +: DQ_W];
    busy       = (state_q == StRef) || (state_q == StGrant);
    // A real end in the expiry cycle wins over the watchdog.
    timeout_err = busy && wd_expire && !end_flag;
    unique case (state_q)
      StInit: begin
        cmd        = init_cmd;
        sdram_addr = init_addr;
      end
      StRef: begin
        cmd        = ref_cmd;
        sdram_addr = ref_addr;
      end
      StGrant: begin
        cmd        = ch_cmd[grant_id_q*4 +: 4];
        sdram_addr = ch_addr[grant_id_q*ADDR_W +: ADDR_W];
        sdram_bank = ch_bank[grant_id_q*BANK_W +: BANK_W];
        sdram_dqm  = ch_dqm[grant_id_q*DQM_W +: DQM_W];
        dq_oe      = ch_dq_oe[grant_id_q];
      end
      default: ;
    endcase
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;
  assign sdram_dq    = dq_oe ? dq_out : {DQ_W{1'bz}};
  assign dq_i        = sdram_dq;
  assign sdram_clk   = ~sclk;
  assign sdram_cke   = 1'b1;
  assign ref_en      = ref_en_q;
  assign ch_en       = ch_en_q;
  assign grant_id    = grant_id_q;

endmodule
